// File: rtl/hamming16t11d_scrubber.sv
// rtl/hamming16t11d_scrubber.sv - background SECDED(16,11) memory scrubber
//
// Purpose:
//    Walks a word-address window, reads each 16-bit hamming vector, checks
//    it with the SECDED(16,11) syndrome (hv[0] = overall parity, parity bits
//    at positions 1,2,4,8, data at the remaining positions), writes back
//    single-error-corrected vectors and counts SEC/DED events.
//
// Ports:
//    clk_i, rst_i                  clock, asynchronous active-high reset
//    en_i                          continuous scrub enable (loops over window)
//    start_i                       one-shot single pass request
//    clr_cnt_i                     synchronous clear of counters and ded_irq_o
//    mem_req_o/we_o/addr_o/wdata_o memory request side, held until mem_gnt_i
//    mem_gnt_i                     request accepted this cycle
//    mem_rvalid_i, mem_rdata_i     read data return
//    busy_o, done_o                status: not idle, end-of-one-shot pulse
//    sec_cnt_o, ded_cnt_o          saturating event counters
//    ded_addr_o, ded_irq_o         last DED address, sticky DED flag

module hamming16t11d_scrubber #(
   parameter int ADDR_WIDTH = 8,
   parameter int INTERVAL   = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  start_i,
   input  logic                  clr_cnt_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [15:0]           mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [15:0]           mem_rdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  sec_cnt_o,
   output logic [CNT_WIDTH-1:0]  ded_cnt_o,
   output logic [ADDR_WIDTH-1:0] ded_addr_o,
   output logic                  ded_irq_o
);

   localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [TW-1:0]         TIMER_LAST = TW'(INTERVAL - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = {ADDR_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_CHECK,
      S_WR_REQ,
      S_WAIT_INT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  oneshot_q, oneshot_d;
   logic [15:0]           hv_q, hv_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [15:0]           wdata_q, wdata_d;
   logic                  done_q, done_d;
   logic [CNT_WIDTH-1:0]  sec_cnt_q, sec_cnt_d;
   logic [CNT_WIDTH-1:0]  ded_cnt_q, ded_cnt_d;
   logic [ADDR_WIDTH-1:0] ded_addr_q, ded_addr_d;
   logic                  ded_irq_q, ded_irq_d;

   logic [3:0] syn;
   logic       par;

   // Each syndrome bit covers the positions whose index has that bit set,
   // so a single flipped bit at position k yields syn == k.
   always_comb begin
      syn[0] = hv_q[1] ^ hv_q[3] ^ hv_q[5]  ^ hv_q[7]  ^
               hv_q[9] ^ hv_q[11] ^ hv_q[13] ^ hv_q[15];
      syn[1] = hv_q[2]  ^ hv_q[3]  ^ hv_q[6]  ^ hv_q[7]  ^
               hv_q[10] ^ hv_q[11] ^ hv_q[14] ^ hv_q[15];
      syn[2] = hv_q[4]  ^ hv_q[5]  ^ hv_q[6]  ^ hv_q[7]  ^
               hv_q[12] ^ hv_q[13] ^ hv_q[14] ^ hv_q[15];
      syn[3] = hv_q[8]  ^ hv_q[9]  ^ hv_q[10] ^ hv_q[11] ^
               hv_q[12] ^ hv_q[13] ^ hv_q[14] ^ hv_q[15];
      par    = ^hv_q;
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      timer_d    = timer_q;
      oneshot_d  = oneshot_q | start_i;
      hv_d       = hv_q;
      req_d      = req_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      sec_cnt_d  = sec_cnt_q;
      ded_cnt_d  = ded_cnt_q;
      ded_addr_d = ded_addr_q;
      ded_irq_d  = ded_irq_q;

      case (state_q)
         S_IDLE: begin
            if (en_i || start_i) begin
               state_d = S_RD_REQ;
               ptr_d   = '0;
               req_d   = 1'b1;
               we_d    = 1'b0;
            end
         end
         S_RD_REQ: begin
            if (mem_gnt_i) begin
               req_d   = 1'b0;
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (mem_rvalid_i) begin
               hv_d    = mem_rdata_i;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            timer_d = '0;
            if (par) begin
               // syn == 0 with odd parity means hv[0] itself flipped.
               wdata_d = hv_q ^ (16'h0001 << syn);
               if (sec_cnt_q != CNT_MAX) sec_cnt_d = sec_cnt_q + 1'b1;
               req_d   = 1'b1;
               we_d    = 1'b1;
               state_d = S_WR_REQ;
            end else if (syn != 4'd0) begin
               if (ded_cnt_q != CNT_MAX) ded_cnt_d = ded_cnt_q + 1'b1;
               ded_addr_d = ptr_q;
               ded_irq_d  = 1'b1;
               state_d    = S_WAIT_INT;
            end else begin
               state_d = S_WAIT_INT;
            end
         end
         S_WR_REQ: begin
            if (mem_gnt_i) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = S_WAIT_INT;
            end
         end
         S_WAIT_INT: begin
            if (timer_q == TIMER_LAST) begin
               timer_d = '0;
               ptr_d   = ptr_q + 1'b1;
               if (ptr_q == PTR_LAST) begin
                  if (oneshot_q) begin
                     done_d    = 1'b1;
                     oneshot_d = 1'b0;
                     state_d   = S_IDLE;
                  end else if (!en_i) begin
                     state_d = S_IDLE;
                  end else begin
                     req_d   = 1'b1;
                     state_d = S_RD_REQ;
                  end
               end else if (en_i || oneshot_q) begin
                  req_d   = 1'b1;
                  state_d = S_RD_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase

      // Clear wins over a same-cycle event.
      if (clr_cnt_i) begin
         sec_cnt_d = '0;
         ded_cnt_d = '0;
         ded_irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         timer_q    <= '0;
         oneshot_q  <= 1'b0;
         hv_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         sec_cnt_q  <= '0;
         ded_cnt_q  <= '0;
         ded_addr_q <= '0;
         ded_irq_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         timer_q    <= timer_d;
         oneshot_q  <= oneshot_d;
         hv_q       <= hv_d;
         req_q      <= req_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         sec_cnt_q  <= sec_cnt_d;
         ded_cnt_q  <= ded_cnt_d;
         ded_addr_q <= ded_addr_d;
         ded_irq_q  <= ded_irq_d;
      end
   end

   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = ptr_q;
   assign mem_wdata_o = wdata_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign sec_cnt_o   = sec_cnt_q;
   assign ded_cnt_o   = ded_cnt_q;
   assign ded_addr_o  = ded_addr_q;
   assign ded_irq_o   = ded_irq_q;

endmodule
